// File: rtl/cdb_result_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdb_result_queue_pkg                                                 |
// | Shared types and defaults for the LS completion (CDB result) queue.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cdb_result_queue_pkg;

  // Width of a renamed register number carried with each result.
  localparam int RRN_BITS = 6;

  // Default log2 entry count of the completion queue (4 entries).
  localparam int CDB_QUEUE_DEPTH_BITS_DEFAULT = 2;

  // One finished load/store result as presented to the CDB.
  typedef struct packed {
    logic [31:0]         result;
    logic [31:0]         address;
    logic [31:0]         result_address;
    logic [4:0]          arn;
    logic [RRN_BITS-1:0] rrn;
    logic                reg_write;
  } cdb_entry_t;

endpackage
`default_nettype wire

// File: rtl/cdb_result_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdb_result_queue                                                     |
// | Circular completion FIFO between the LS unit and the CDB arbiter.    |
// | The oldest entry is offered on o_get_bus/o_head until granted.       |
// | Option macro: CDB_QUEUE_BYPASS_EN (zero-latency path when empty).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cdb_result_queue
  import cdb_result_queue_pkg::*;
#(
  parameter int DEPTH_BITS = CDB_QUEUE_DEPTH_BITS_DEFAULT  // legal 1..4
) (
  input  logic                clk,       // CSB clock
  input  logic                reset,     // CSB reset: synchronous, active-high
  input  logic                i_clear,
  input  logic                i_push,
  input  cdb_entry_t          i_entry,
  output logic                o_full,
  output logic                o_empty,
  output logic [DEPTH_BITS:0] o_count,
  output logic                o_drop,
  output logic                o_get_bus,
  input  logic                i_bus_granted,
  output cdb_entry_t          o_head
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  cdb_entry_t            storage [DEPTH];
  logic [DEPTH_BITS:0]   wr_ptr;
  logic [DEPTH_BITS:0]   rd_ptr;
  logic [DEPTH_BITS-1:0] wr_idx;
  logic [DEPTH_BITS-1:0] rd_idx;
  logic                  drop_q;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  bypass_take;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign wr_idx  = wr_ptr[DEPTH_BITS-1:0];
  assign rd_idx  = rd_ptr[DEPTH_BITS-1:0];
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) && (wr_idx == rd_idx);
  assign o_count = wr_ptr - rd_ptr;
  assign o_drop  = drop_q;

`ifdef CDB_QUEUE_BYPASS_EN
  logic bypass;
  // An incoming result skips storage when nothing older is waiting.
  assign bypass      = o_empty & i_push;
  assign o_get_bus   = ~o_empty | i_push;
  assign o_head      = bypass ? i_entry : storage[rd_idx];
  assign bypass_take = bypass & i_bus_granted;
`else
  // Request depends only on registered pointers, so no grant->request loop.
  assign o_get_bus   = ~o_empty;
  assign o_head      = storage[rd_idx];
  assign bypass_take = 1'b0;
`endif

  // Full is judged on the registered state: a same-cycle pop frees nothing.
  assign push_ok = i_push & ~o_full & ~bypass_take;
  assign pop_ok  = i_bus_granted & ~o_empty;

  // Pointer, storage and drop-pulse update; reset > clear > push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= i_push & o_full;
      if (push_ok) begin
        storage[wr_idx] <= i_entry;
        wr_ptr          <= wr_ptr + (DEPTH_BITS+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + (DEPTH_BITS+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire
